instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  instruction memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address, always equal to pc_out.
REQ-006 imem_ack  input  1  memory response strobe; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall  input  1  downstream not ready; holds the current instruction.
REQ-009 branch_taken  input  1  current instruction is a taken conditional branch.
REQ-010 branch_ext  input  32  sign-extended 16-bit branch offset, in words, from the sign-extension stage.
REQ-011 jump  input  1  current instruction is J-type.
REQ-012 jump_target  input  26  J-type target field.
REQ-013 pc_out  output  32  address of the held or pending instruction.
REQ-014 pc_plus4  output  32  pc_out + 4, modulo 2^32.
REQ-015 instr  output  32  latched instruction word.
REQ-016 imm  output  16  instr[15:0], fed to the sign-extension stage.
REQ-017 instr_valid  output  1  instr, imm and pc_out describe a valid fetched instruction.

Function
REQ-018 FSM states: IDLE, REQ, HOLD.
REQ-019 IDLE lasts exactly one cycle after reset release, then moves to REQ; imem_req=0 and instr_valid=0 in IDLE.
REQ-020 REQ: imem_req=1, and imem_addr stays stable until imem_ack.
REQ-021 REQ with imem_ack=1: latch imem_rdata into instr; next state HOLD; imem_req drops on the next cycle.
REQ-022 HOLD: instr_valid=1, imem_req=0.
REQ-023 HOLD with stall=1: stay in HOLD; pc_out and instr stay unchanged; branch_taken and jump are ignored.
REQ-024 HOLD with stall=0: load the next PC and go to REQ.
REQ-025 Next-PC priority: jump over branch_taken over sequential.
REQ-026 Jump target: {pc_plus4[31:28], jump_target, 2'b00}.
REQ-027 Branch target: pc_plus4 + (branch_ext << 2), truncated to 32 bits; negative offsets and wrap-around past 32'hFFFF_FFFC are permitted.
REQ-028 Sequential target: pc_plus4; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-029 Next-PC is always word-aligned; bits [1:0] of pc_out are always 0.
REQ-030 Fetch-to-valid latency: instr_valid rises on the cycle after imem_ack is sampled.
REQ-031 branch_taken, jump and imem_ack are sampled only in their owning states (HOLD and REQ respectively); outside those states they have no effect.
REQ-032 instr_valid drops in the first REQ cycle after a PC update; the sign-extension stage sees no stale imm qualified by instr_valid.

Reset
REQ-033 rst=1 asynchronously forces: state IDLE, pc_out=RESET_PC, instr=32'h0, imm=16'h0, instr_valid=0, imem_req=0.
REQ-034 Reset mid-request (state REQ): the outstanding request is abandoned; an imem_ack arriving during or after reset but before the next REQ is ignored.
REQ-035 pc_plus4 reflects RESET_PC+4 during reset.

Verification
REQ-036 Reset, then imem_ack on the 2nd REQ cycle with rdata=32'h2008_000A -> imem_addr=0, instr=32'h2008_000A, imm=16'h000A, instr_valid=1, pc_out=0.
REQ-037 HOLD at pc=32'h0000_0040, stall=0, no branch or jump -> next imem_addr=32'h0000_0044.
REQ-038 HOLD at pc=32'h0000_0040, branch_taken=1, branch_ext=32'hFFFF_FFFC -> next pc=32'h0000_0034; with branch_ext=32'h0000_0003 -> next pc=32'h0000_0050.
REQ-039 HOLD at pc=32'h1000_0000, jump=1, branch_taken=1, jump_target=26'h000_0010 -> next pc=32'h1000_0040 (jump wins).
REQ-040 stall=1 for 5 cycles in HOLD with branch_taken toggling -> pc_out, instr and instr_valid unchanged, imem_req=0; release stall -> exactly one PC update.
REQ-041 rst asserted while in REQ at pc=32'h0000_0080, imem_ack pulsed during reset -> pc_out=RESET_PC, instr_valid=0; first post-reset fetch address = RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequences memory reads, holds the fetched word for
// the decode/sign-extension stages, and selects the next PC.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_ext,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [15:0] imm,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } state_t;

    // Low address bits are forced to zero so pc_out is word-aligned even for
    // a misaligned RESET_PC override.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] RESET_PC_PLUS4   = RESET_PC_ALIGNED + 32'd4;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_r;
    logic [31:0] instr_r;
    logic        instr_valid_r;
    logic        imem_req_r;

    logic [31:0] jump_pc_s;
    logic [31:0] branch_pc_s;
    logic [31:0] next_pc_s;

    // Next-PC selection: jump beats branch beats sequential.
    always_comb begin
        jump_pc_s   = {pc_plus4_r[31:28], jump_target, 2'b00};
        branch_pc_s = pc_plus4_r + {branch_ext[29:0], 2'b00};
        next_pc_s   = pc_plus4_r;
        if (jump) begin
            next_pc_s = jump_pc_s;
        end else if (branch_taken) begin
            next_pc_s = branch_pc_s;
        end else begin
            next_pc_s = pc_plus4_r;
        end
    end

    // Fetch FSM with all outputs held in registers; ack and redirect inputs
    // are only looked at in the state that owns them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC_ALIGNED;
            pc_plus4_r    <= RESET_PC_PLUS4;
            instr_r       <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            imem_req_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r       <= REQ;
                    imem_req_r    <= 1'b1;
                    instr_valid_r <= 1'b0;
                end
                REQ: begin
                    if (imem_ack) begin
                        state_r       <= HOLD;
                        instr_r       <= imem_rdata;
                        instr_valid_r <= 1'b1;
                        imem_req_r    <= 1'b0;
                    end else begin
                        state_r       <= REQ;
                        imem_req_r    <= 1'b1;
                        instr_valid_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (stall) begin
                        state_r       <= HOLD;
                        instr_valid_r <= 1'b1;
                        imem_req_r    <= 1'b0;
                    end else begin
                        // Drop valid together with the PC change so imm is
                        // never presented as valid for the new address.
                        state_r       <= REQ;
                        pc_r          <= next_pc_s;
                        pc_plus4_r    <= next_pc_s + 32'd4;
                        instr_valid_r <= 1'b0;
                        imem_req_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    instr_valid_r <= 1'b0;
                    imem_req_r    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign pc_out      = pc_r;
    assign pc_plus4    = pc_plus4_r;
    assign instr       = instr_r;
    assign imm         = instr_r[15:0];
    assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: reset, fetch handshake,
// next-PC selection, stall hold and reset during an outstanding request.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_ext;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [15:0] imm;
    logic        instr_valid;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_ext(branch_ext),
        .jump(jump), .jump_target(jump_target),
        .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instr(instr), .imm(imm), .instr_valid(instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for a request, then acks it with data; ends in HOLD.
    task automatic do_fetch(input logic [31:0] data);
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (imem_req !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL fetch_timeout imem_req got %b exp 1", imem_req);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    // From HOLD, releases one PC update with the given redirect inputs.
    task automatic redirect(input logic j, input logic b,
                            input logic [31:0] ext, input logic [25:0] tgt);
        stall        = 1'b0;
        jump         = j;
        branch_taken = b;
        branch_ext   = ext;
        jump_target  = tgt;
        @(negedge clk);
        jump         = 1'b0;
        branch_taken = 1'b0;
        branch_ext   = 32'h0000_0000;
        jump_target  = 26'h000_0000;
    endtask

    task automatic test_reset;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0000_0000;
        stall = 1'b0; branch_taken = 1'b0; branch_ext = 32'h0000_0000;
        jump = 1'b0; jump_target = 26'h000_0000;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (pc_out !== 32'h0000_0000) begin n_err++; $display("FAIL rst_pc got %h exp %h", pc_out, 32'h0); end
        n_cmp++; if (pc_plus4 !== 32'h0000_0004) begin n_err++; $display("FAIL rst_pc_plus4 got %h exp %h", pc_plus4, 32'h4); end
        n_cmp++; if (instr !== 32'h0000_0000) begin n_err++; $display("FAIL rst_instr got %h exp 0", instr); end
        n_cmp++; if (imm !== 16'h0000) begin n_err++; $display("FAIL rst_imm got %h exp 0", imm); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req got %b exp 0", imem_req); end
    endtask

    task automatic test_first_fetch;
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL req1_req got %b exp 1", imem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL req1_valid got %b exp 0", instr_valid); end
        @(negedge clk);
        n_cmp++; if (imem_addr !== 32'h0000_0000) begin n_err++; $display("FAIL req2_addr got %h exp 0", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL req2_req got %b exp 1", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'h2008_000A;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        n_cmp++; if (instr !== 32'h2008_000A) begin n_err++; $display("FAIL ff_instr got %h exp %h", instr, 32'h2008_000A); end
        n_cmp++; if (imm !== 16'h000A) begin n_err++; $display("FAIL ff_imm got %h exp %h", imm, 16'h000A); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL ff_valid got %b exp 1", instr_valid); end
        n_cmp++; if (pc_out !== 32'h0000_0000) begin n_err++; $display("FAIL ff_pc got %h exp 0", pc_out); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL ff_req got %b exp 0", imem_req); end
        // Branch +15 words from 0 lands on 0x40.
        redirect(1'b0, 1'b1, 32'h0000_000F, 26'h000_0000);
        n_cmp++; if (pc_out !== 32'h0000_0040) begin n_err++; $display("FAIL nav40_pc got %h exp %h", pc_out, 32'h40); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL nav40_valid got %b exp 0", instr_valid); end
        do_fetch(32'h0000_1111);
    endtask

    task automatic test_sequential;
        redirect(1'b0, 1'b0, 32'h0000_0000, 26'h000_0000);
        n_cmp++; if (imem_addr !== 32'h0000_0044) begin n_err++; $display("FAIL seq_addr got %h exp %h", imem_addr, 32'h44); end
        n_cmp++; if (pc_plus4 !== 32'h0000_0048) begin n_err++; $display("FAIL seq_plus4 got %h exp %h", pc_plus4, 32'h48); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL seq_req got %b exp 1", imem_req); end
        do_fetch(32'h0000_2222);
        redirect(1'b0, 1'b1, 32'hFFFF_FFFE, 26'h000_0000);
        n_cmp++; if (pc_out !== 32'h0000_0040) begin n_err++; $display("FAIL back40_pc got %h exp %h", pc_out, 32'h40); end
        do_fetch(32'h0000_3333);
    endtask

    task automatic test_branch;
        redirect(1'b0, 1'b1, 32'hFFFF_FFFC, 26'h000_0000);
        n_cmp++; if (pc_out !== 32'h0000_0034) begin n_err++; $display("FAIL br_neg_pc got %h exp %h", pc_out, 32'h34); end
        do_fetch(32'h0000_4444);
        redirect(1'b0, 1'b1, 32'h0000_0002, 26'h000_0000);
        n_cmp++; if (pc_out !== 32'h0000_0040) begin n_err++; $display("FAIL br_fwd2_pc got %h exp %h", pc_out, 32'h40); end
        do_fetch(32'h0000_5555);
        redirect(1'b0, 1'b1, 32'h0000_0003, 26'h000_0000);
        n_cmp++; if (pc_out !== 32'h0000_0050) begin n_err++; $display("FAIL br_pos_pc got %h exp %h", pc_out, 32'h50); end
        do_fetch(32'h0000_6666);
    endtask

    task automatic test_jump;
        // 0x54 + 0x03FF_FFEB*4 = 0x1000_0000
        redirect(1'b0, 1'b1, 32'h03FF_FFEB, 26'h000_0000);
        n_cmp++; if (pc_out !== 32'h1000_0000) begin n_err++; $display("FAIL nav1000_pc got %h exp %h", pc_out, 32'h1000_0000); end
        do_fetch(32'h0000_7777);
        redirect(1'b1, 1'b1, 32'h0000_0005, 26'h000_0010);
        n_cmp++; if (pc_out !== 32'h1000_0040) begin n_err++; $display("FAIL jump_pc got %h exp %h", pc_out, 32'h1000_0040); end
        do_fetch(32'h0000_8888);
    endtask

    task automatic test_wrap;
        // 0x1000_0044 + 0xEFFF_FFB8 = 0xFFFF_FFFC
        redirect(1'b0, 1'b1, 32'h3BFF_FFEE, 26'h000_0000);
        n_cmp++; if (pc_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL navtop_pc got %h exp %h", pc_out, 32'hFFFF_FFFC); end
        n_cmp++; if (pc_plus4 !== 32'h0000_0000) begin n_err++; $display("FAIL top_plus4 got %h exp 0", pc_plus4); end
        do_fetch(32'h0000_9999);
        redirect(1'b0, 1'b0, 32'h0000_0000, 26'h000_0000);
        n_cmp++; if (pc_out !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pc got %h exp 0", pc_out); end
        n_cmp++; if (pc_plus4 !== 32'h0000_0004) begin n_err++; $display("FAIL wrap_plus4 got %h exp 4", pc_plus4); end
    endtask

    task automatic test_stall;
        do_fetch(32'hDEAD_BEEF);
        stall = 1'b1;
        branch_ext = 32'h0000_0007;
        jump_target = 26'h000_0100;
        for (int i = 0; i < 5; i++) begin
            branch_taken = i[0];
            jump = ~i[0];
            @(negedge clk);
            n_cmp++; if (pc_out !== 32'h0000_0000) begin n_err++; $display("FAIL stall_pc[%0d] got %h exp 0", i, pc_out); end
            n_cmp++; if (instr !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL stall_instr[%0d] got %h exp %h", i, instr, 32'hDEAD_BEEF); end
            n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b exp 1", i, instr_valid); end
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d] got %b exp 0", i, imem_req); end
        end
        redirect(1'b0, 1'b0, 32'h0000_0000, 26'h000_0000);
        n_cmp++; if (pc_out !== 32'h0000_0004) begin n_err++; $display("FAIL unstall_pc got %h exp 4", pc_out); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL unstall_valid got %b exp 0", instr_valid); end
        @(negedge clk);
        n_cmp++; if (pc_out !== 32'h0000_0004) begin n_err++; $display("FAIL one_update_pc got %h exp 4", pc_out); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL one_update_req got %b exp 1", imem_req); end
    endtask

    task automatic test_reset_mid_req;
        do_fetch(32'h0000_AAAA);
        // 0x8 + 0x1E*4 = 0x80
        redirect(1'b0, 1'b1, 32'h0000_001E, 26'h000_0000);
        n_cmp++; if (pc_out !== 32'h0000_0080) begin n_err++; $display("FAIL nav80_pc got %h exp %h", pc_out, 32'h80); end
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1;
        n_cmp++; if (pc_out !== 32'h0000_0000) begin n_err++; $display("FAIL mrst_pc got %h exp 0", pc_out); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b exp 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mrst_req got %b exp 0", imem_req); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        n_cmp++; if (imem_addr !== 32'h0000_0000) begin n_err++; $display("FAIL post_addr got %h exp 0", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL post_req got %b exp 1", imem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL post_valid got %b exp 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0000_0000) begin n_err++; $display("FAIL post_instr got %h exp 0", instr); end
        do_fetch(32'h1234_5678);
        n_cmp++; if (instr !== 32'h1234_5678) begin n_err++; $display("FAIL post_fetch_instr got %h exp %h", instr, 32'h1234_5678); end
        n_cmp++; if (pc_out !== 32'h0000_0000) begin n_err++; $display("FAIL post_fetch_pc got %h exp 0", pc_out); end
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_sequential;
        test_branch;
        test_jump;
        test_wrap;
        test_stall;
        test_reset_mid_req;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
